// File: rtl/sync_ram_if.sv
// Bus bundle for sync_ram: write enable, shared address, write data and
// registered read data. The master drives the request side; the RAM is the slave.
interface sync_ram_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output we,
    output address,
    output data_in,
    input  data_out
  );

  modport slave (
    input  we,
    input  address,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered, write-first read port.
// Storage is plain flip-flops so a synchronous reset can clear every word.
module sync_ram #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  sync_ram_if.slave      bus
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DEPTH-1:0]      word_sel;

  // One write strobe per word: full decode, so no two addresses alias.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
    assign word_sel[gi] = bus.we && (bus.address == ADDR_WIDTH'(gi));
  end

  // Next-state of the array: only the strobed word takes data_in.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = word_sel[i] ? bus.data_in : mem_q[i];
    end
  end

  // Read path: a write forwards its own data (write-first), otherwise the stored word.
  always_comb begin
    data_out_d = bus.we ? bus.data_in : mem_q[bus.address];
  end

  // State update; reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_sync_ram.sv
// Directed bench for sync_ram: reset clear, write/read-back, isolation,
// we=0 writes, reset priority and overwrite, with hand-computed expectations.
module tb_sync_ram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  sync_ram_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) bus ();

  sync_ram #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it on mismatch (X counts as mismatch).
  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: data_out=%h", tag, obs);
    end
  endtask

  // Present inputs, take one rising edge, settle 1 time unit past it.
  task automatic cycle(input logic r, input logic w, input logic [3:0] a, input logic [3:0] d);
    rst         = r;
    bus.we      = w;
    bus.address = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.we = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    #2;

    // Power-up reset
    cycle(1'b1, 1'b0, 4'd0, 4'd0);
    check_eq("reset_out", bus.data_out, 4'h0);
    cycle(1'b0, 1'b0, 4'd5, 4'd0);
    check_eq("reset_mem5", bus.data_out, 4'h0);

    // Reset clear of previously written words
    cycle(1'b0, 1'b1, 4'd0, 4'hF);
    check_eq("wf_a0", bus.data_out, 4'hF);
    cycle(1'b0, 1'b1, 4'd8, 4'hF);
    check_eq("wf_a8", bus.data_out, 4'hF);
    cycle(1'b0, 1'b1, 4'd15, 4'hF);
    check_eq("wf_a15", bus.data_out, 4'hF);
    cycle(1'b1, 1'b0, 4'd15, 4'd0);
    check_eq("rst_edge", bus.data_out, 4'h0);
    cycle(1'b0, 1'b0, 4'd0, 4'd0);
    check_eq("clr_a0", bus.data_out, 4'h0);
    cycle(1'b0, 1'b0, 4'd8, 4'd0);
    check_eq("clr_a8", bus.data_out, 4'h0);
    cycle(1'b0, 1'b0, 4'd15, 4'd0);
    check_eq("clr_a15", bus.data_out, 4'h0);

    // Write / read-back
    cycle(1'b0, 1'b1, 4'd8, 4'd10);
    check_eq("wr8_first", bus.data_out, 4'd10);
    cycle(1'b0, 1'b0, 4'd0, 4'd0);
    check_eq("rd0_a", bus.data_out, 4'd0);
    cycle(1'b0, 1'b0, 4'd8, 4'd0);
    check_eq("rd8", bus.data_out, 4'd10);
    // Address moving between edges must not disturb the registered output
    bus.address = 4'd0;
    #3;
    check_eq("hold_between_edges", bus.data_out, 4'd10);
    cycle(1'b0, 1'b0, 4'd0, 4'd0);
    check_eq("rd0_b", bus.data_out, 4'd0);

    // Isolation: every address holds (addr+1)&F
    for (int a = 0; a < 16; a++) begin
      logic [3:0] v;
      v = 4'(a + 1);
      cycle(1'b0, 1'b1, 4'(a), v);
    end
    for (int a = 0; a < 16; a++) begin
      logic [3:0] v;
      v = 4'(a + 1);
      cycle(1'b0, 1'b0, 4'(a), 4'd0);
      check_eq($sformatf("iso_a%0d", a), bus.data_out, v);
    end

    // we=0 must not write
    cycle(1'b1, 1'b0, 4'd0, 4'd0);
    cycle(1'b0, 1'b0, 4'd3, 4'd5);
    check_eq("nowe_same_cycle", bus.data_out, 4'd0);
    cycle(1'b0, 1'b0, 4'd3, 4'd0);
    check_eq("nowe_rd3", bus.data_out, 4'd0);

    // Reset beats a simultaneous write
    cycle(1'b1, 1'b1, 4'd2, 4'd7);
    check_eq("rstpri_edge", bus.data_out, 4'd0);
    cycle(1'b0, 1'b0, 4'd2, 4'd0);
    check_eq("rstpri_rd2", bus.data_out, 4'd0);

    // Overwrite: last write wins, neighbours untouched
    cycle(1'b0, 1'b1, 4'd12, 4'd9);
    check_eq("ow_w9", bus.data_out, 4'd9);
    cycle(1'b0, 1'b1, 4'd12, 4'd6);
    check_eq("ow_w6", bus.data_out, 4'd6);
    cycle(1'b0, 1'b0, 4'd12, 4'd0);
    check_eq("ow_rd12", bus.data_out, 4'd6);
    cycle(1'b0, 1'b0, 4'd13, 4'd0);
    check_eq("ow_rd13", bus.data_out, 4'd0);
    cycle(1'b0, 1'b0, 4'd4, 4'd0);
    check_eq("ow_rd4", bus.data_out, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
